pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 next_pc  input  32  candidate PC from the PC-select mux (output_sel_pc).
REQ-005 pc_write  input  1  unconditional PC load request.
REQ-006 pc_write_cond  input  1  conditional (branch) PC load request.
REQ-007 zero  input  1  ALU zero flag qualifying pc_write_cond.
REQ-008 fetch_req  input  1  request instruction fetch at current PC.
REQ-009 imem_ready  input  1  instruction memory has accepted/completed the access.
REQ-010 pc  output  32  current PC register.
REQ-011 imem_addr  output  32  fetch address, latched at fetch start.
REQ-012 imem_req  output  1  memory request, high throughout FETCH.
REQ-013 fetch_valid  output  1  one-cycle pulse on fetch completion.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 misaligned  output  1  one-cycle pulse on rejected misaligned load (see Configuration).

Function
REQ-016 Load condition ld = pc_write | (pc_write_cond & zero); both together count as one load.
REQ-017 In IDLE, ld SHALL load next_pc into pc on the same edge (1-cycle latency, visible next cycle).
REQ-018 FSM states SHALL be IDLE, FETCH, DONE; encoding free.
REQ-019 IDLE -> FETCH on fetch_req; imem_addr <= pc on that edge; if ld in same cycle, imem_addr SHALL use the old pc and pc takes next_pc.
REQ-020 FETCH: imem_req=1, imem_addr stable; stay until imem_ready=1, then -> DONE.
REQ-021 DONE: fetch_valid=1 for exactly one cycle; -> IDLE next edge; fetch_req in DONE ignored.
REQ-022 ld during FETCH or DONE SHALL NOT change pc; next_pc captured into a pending register (last one wins) with pending flag set.
REQ-023 On DONE -> IDLE edge, a pending load SHALL be applied to pc and pending cleared; an ld asserted in that same DONE cycle overrides any earlier pending value.
REQ-024 imem_ready in IDLE or DONE SHALL be ignored.
REQ-025 No arithmetic on pc; all 32 bits passed unmodified (wrap handled upstream).

Reset
REQ-026 reset SHALL, on the next rising edge, set pc=RESET_PC, imem_addr=RESET_PC, state=IDLE, pending cleared, imem_req=0, fetch_valid=0, busy=0, misaligned=0.
REQ-027 reset SHALL take priority over all inputs, including mid-FETCH; the outstanding access is abandoned without fetch_valid.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN: when defined, any load (immediate or pending capture) with next_pc[1:0]!=2'b00 SHALL be rejected, pc/pending unchanged, misaligned pulsed one cycle after the offending ld.
REQ-029 Without PC_ALIGN_CHECK_EN, next_pc SHALL be loaded unchecked and misaligned SHALL be constant 0.

Verification
REQ-030 reset high 1 cycle, RESET_PC=32'h0000_0400 -> pc=imem_addr=32'h400, busy=0, imem_req=0.
REQ-031 IDLE, next_pc=32'h0000_0010, pc_write=1 one cycle -> pc=32'h10 next cycle; then pc_write_cond=1, zero=0, next_pc=32'h20 -> pc stays 32'h10.
REQ-032 fetch_req at pc=32'h10, imem_ready after 3 cycles -> imem_req high 3 cycles, imem_addr=32'h10, fetch_valid one pulse, busy clears following cycle.
REQ-033 pc_write with next_pc=32'h40 then 32'h44 during FETCH -> pc holds 32'h10 until DONE->IDLE edge, then pc=32'h44.
REQ-034 reset asserted mid-FETCH -> no fetch_valid, pc=RESET_PC, state IDLE next cycle.
REQ-035 With PC_ALIGN_CHECK_EN, pc_write next_pc=32'h0000_0022 -> pc unchanged, misaligned one-cycle pulse; without macro -> pc=32'h22, misaligned=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter register with a three-state instruction
// fetch sequencer (IDLE -> FETCH -> DONE).
// PC loads requested while a fetch is in flight are deferred and applied
// on the DONE -> IDLE edge (last request wins).
// Optional feature macro: PC_ALIGN_CHECK_EN rejects loads whose target is not
// word aligned and pulses `misaligned`; when undefined, loads are unchecked
// and `misaligned` is tied low.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic        fetch_req,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        busy,
  output logic        misaligned
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] imem_addr_q;
  logic [PC_W-1:0] pend_pc_q;
  logic            pend_vld_q;
  logic            imem_req_q;
  logic            fetch_valid_q;
  logic            busy_q;
  logic            misaligned_q;

  logic            ld_c;
  logic            reject_c;
  logic            accept_c;

  // Load request: unconditional write or taken branch; both together are one load.
  assign ld_c = pc_write | (pc_write_cond & zero);

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned targets are refused outright, whether immediate or deferred.
  assign reject_c = ld_c & (next_pc[1:0] != 2'b00);
`else
  assign reject_c = 1'b0;
`endif

  assign accept_c = ld_c & ~reject_c;

  // Fetch sequencer, PC register, deferred-load capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      imem_addr_q   <= RESET_PC;
      pend_pc_q     <= RESET_PC;
      pend_vld_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      misaligned_q <= reject_c;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            pc_q <= next_pc;
          end
          if (fetch_req) begin
            // Address uses the pre-load PC even when a load lands on this edge.
            imem_addr_q <= pc_q;
            imem_req_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (accept_c) begin
            pend_pc_q  <= next_pc;
            pend_vld_q <= 1'b1;
          end
          if (imem_ready) begin
            imem_req_q    <= 1'b0;
            fetch_valid_q <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A load arriving in DONE supersedes any earlier deferred target.
          if (accept_c) begin
            pc_q <= next_pc;
          end else if (pend_vld_q) begin
            pc_q <= pend_pc_q;
          end
          pend_vld_q    <= 1'b0;
          fetch_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          imem_req_q    <= 1'b0;
          fetch_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          pend_vld_q    <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = imem_addr_q;
  assign imem_req    = imem_req_q;
  assign fetch_valid = fetch_valid_q;
  assign busy        = busy_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random traffic,
// checked against a transaction-level model and a fetch-address scoreboard.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic        zero;
  logic        fetch_req;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        fetch_valid;
  logic        busy;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of fetch addresses awaiting a completion pulse.
  logic [31:0] exp_q[$];

  // Reference model: PC value, latched fetch address, fetch phase
  // (0 = idle, 1 = memory access outstanding, 2 = completing),
  // loads deferred during a fetch, and the misaligned flag.
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  int          m_phase = 0;
  logic [31:0] m_defer[$];
  logic        m_mis;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .zero         (zero),
    .fetch_req    (fetch_req),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .fetch_valid  (fetch_valid),
    .busy         (busy),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and check outputs after the edge.
  task automatic cycle(input logic rst, input logic pw, input logic pwc, input logic z,
                       input logic fr, input logic rdy, input logic [31:0] nx);
    logic ld;
    logic bad;
    logic good;
    reset         = rst;
    pc_write      = pw;
    pc_write_cond = pwc;
    zero          = z;
    fetch_req     = fr;
    imem_ready    = rdy;
    next_pc       = nx;

    ld = pw | (pwc & z);
`ifdef PC_ALIGN_CHECK_EN
    bad = ld && (nx[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    good = ld && !bad;

    if (rst) begin
      if (m_phase == 1) exp_q.delete();
      m_pc    = RPC;
      m_addr  = RPC;
      m_phase = 0;
      m_defer.delete();
      m_mis   = 1'b0;
    end else begin
      m_mis = bad;
      if (m_phase == 0) begin
        if (fr) begin
          m_addr = m_pc;
          exp_q.push_back(m_pc);
          m_phase = 1;
        end
        if (good) m_pc = nx;
      end else if (m_phase == 1) begin
        if (good) m_defer.push_back(nx);
        if (rdy) m_phase = 2;
      end else begin
        if (good) m_defer.push_back(nx);
        if (m_defer.size() > 0) m_pc = m_defer[$];
        m_defer.delete();
        m_phase = 0;
      end
    end

    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_req", 32'(imem_req), 32'(m_phase == 1));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("fetch_valid", 32'(fetch_valid), 32'(m_phase == 2));
    chk("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  // Completion monitor: each fetch_valid pulse must match the oldest issued fetch.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual=1 required=0");
      end else begin
        chk("sb_fetch_addr", imem_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] nx;
    reset = 1'b1; pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;
    fetch_req = 1'b0; imem_ready = 1'b0; next_pc = 32'h0;
    m_pc = RPC; m_addr = RPC; m_mis = 1'b0;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_pc", pc, 32'h0000_0400);
    chk("rst_addr", imem_addr, 32'h0000_0400);

    // Unconditional load, then a not-taken branch.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
    chk("ld_pc", pc, 32'h0000_0010);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020);
    chk("nt_branch_pc", pc, 32'h0000_0010);

    // Fetch with ready in the third access cycle and two deferred loads.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
    chk("defer_pc_hold", pc, 32'h0000_0010);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044);
    chk("done_pulse", 32'(fetch_valid), 32'd1);
    chk("done_addr", imem_addr, 32'h0000_0010);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("deferred_applied", pc, 32'h0000_0044);
    chk("busy_clear", 32'(busy), 32'd0);

    // Reset in the middle of a fetch.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("midfetch_rst_pc", pc, 32'h0000_0400);
    chk("midfetch_rst_valid", 32'(fetch_valid), 32'd0);

    // Misaligned load target.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0022);
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign_pc", pc, 32'h0000_0400);
    chk("misalign_flag", 32'(misaligned), 32'd1);
`else
    chk("misalign_pc", pc, 32'h0000_0022);
    chk("misalign_flag", 32'(misaligned), 32'd0);
`endif
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("misalign_pulse_end", 32'(misaligned), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      nx = $urandom();
      if ($urandom_range(3, 0) != 0) nx[1:0] = 2'b00;
      cycle(($urandom_range(63, 0) == 0),
            ($urandom_range(3, 0) == 0),
            ($urandom_range(3, 0) == 0),
            1'($urandom_range(1, 0)),
            ($urandom_range(2, 0) == 0),
            ($urandom_range(2, 0) == 0),
            nx);
    end

    // Drain any outstanding fetch so the scoreboard empties.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    end
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
